ahb_write_master: RTL

AHB-Lite write master that drains packed 32-bit pixel words from the write-side FIFO stage (`fifo_w`) into system memory. It sits directly downstream of `fifo_w`. Software-programmed start address and word count arrive via a `start` pulse. The block issues INCR word bursts with correct address/data-phase pipelining, wait-state handling, 1 KB boundary splitting and error abort.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_wm_addr_gen.sv | 50 +++++
 rtl/ahb_write_master.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the write-master state type.
package ahb_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HBURST_INCR = 3'b001;

  typedef enum logic [2:0] {
    WM_IDLE,
    WM_ADDR,
    WM_DATA_LAST,
    WM_ERR1,
    WM_ERR2,
    WM_DONE
  } wm_state_t;

endpackage

// File: rtl/ahb_wm_addr_gen.sv
// Word address generator: +4 increment, 1 KB boundary flag and issue counter
// with a last-beat flag for the AHB write master.
module ahb_wm_addr_gen
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_bound,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bound;
  logic [ADDR_W-1:0] w_load_addr;
  logic [ADDR_W-1:0] w_next_addr;

  // Byte offset bits are forced to zero so every beat is word aligned.
  assign w_load_addr = i_addr & ~ADDR_W'(3);
  assign w_next_addr = r_addr + ADDR_W'(4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_bound <= 1'b0;
    end else if (i_load) begin
      r_addr  <= w_load_addr;
      r_cnt   <= i_cnt;
      r_bound <= (w_load_addr[9:0] == 10'd0);
    end else if (i_adv) begin
      r_addr  <= w_next_addr;
      r_cnt   <= r_cnt - CNT_W'(1);
      r_bound <= (w_next_addr[9:0] == 10'd0);
    end
  end

  assign o_addr  = r_addr;
  assign o_bound = r_bound;
  assign o_last  = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/ahb_write_master.sv
// AHB-Lite INCR write master draining fifo_w into memory.
// Define AHB_WM_BUSY_EN to signal mid-burst FIFO stalls with HTRANS=BUSY.
module ahb_write_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_left
);

  wm_state_t         r_state;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_dphase;
  logic              r_first;
  logic              r_gap;
  logic [CNT_W-1:0]  r_words_left;

  logic              w_load;
  logic              w_in_addr;
  logic              w_err;
  logic              w_hs;
  logic              w_last;
  logic              w_bound;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_htrans;

  assign w_load      = (r_state == WM_IDLE) && start;
  assign w_in_addr   = (r_state == WM_ADDR);
  assign w_err       = r_dphase && HRESP && !HREADY;
  assign wdata_ready = w_in_addr && HREADY;
  assign w_hs        = wdata_ready && wdata_valid;

  ahb_wm_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_load  (w_load),
    .i_addr  (start_addr),
    .i_cnt   (num_words),
    .i_adv   (w_hs),
    .o_addr  (w_addr),
    .o_bound (w_bound),
    .o_last  (w_last)
  );

  // Transfer type follows FIFO availability; the first error cycle cancels it.
  always_comb begin
    w_htrans = HTRANS_IDLE;
    if (w_in_addr && !w_err) begin
      if (wdata_valid) begin
        w_htrans = (r_first || r_gap || w_bound) ? HTRANS_NONSEQ : HTRANS_SEQ;
      end
`ifdef AHB_WM_BUSY_EN
      else if (!r_first) begin
        w_htrans = HTRANS_BUSY;
      end
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= WM_IDLE;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_dphase     <= 1'b0;
      r_first      <= 1'b0;
      r_gap        <= 1'b0;
      r_words_left <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hs) begin
        r_wdata <= wdata_in;
      end
      if (w_hs) begin
        r_dphase <= 1'b1;
      end else if (HREADY) begin
        r_dphase <= 1'b0;
      end
      if (r_dphase && HREADY && !HRESP) begin
        r_words_left <= r_words_left - CNT_W'(1);
      end

      case (r_state)
        // Zero-length jobs pass through DATA_LAST with no data phase pending.
        WM_IDLE: begin
          if (start) begin
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_first      <= 1'b1;
            r_gap        <= 1'b0;
            r_words_left <= num_words;
            r_state      <= (num_words == '0) ? WM_DATA_LAST : WM_ADDR;
          end
        end
        WM_ADDR: begin
          if (w_err) begin
            r_error <= 1'b1;
            r_state <= WM_ERR1;
          end else if (w_hs) begin
            r_first <= 1'b0;
            r_gap   <= 1'b0;
            if (w_last) begin
              r_state <= WM_DATA_LAST;
            end
          end
`ifndef AHB_WM_BUSY_EN
          else if (!wdata_valid) begin
            r_gap <= 1'b1;
          end
`endif
        end
        WM_DATA_LAST: begin
          if (w_err) begin
            r_error <= 1'b1;
            r_state <= WM_ERR1;
          end else if (!r_dphase || HREADY) begin
            r_done  <= 1'b1;
            r_state <= WM_DONE;
          end
        end
        WM_ERR1: begin
          if (HREADY) begin
            r_state <= WM_ERR2;
          end
        end
        WM_ERR2: begin
          r_done  <= 1'b1;
          r_state <= WM_DONE;
        end
        WM_DONE: begin
          r_busy  <= 1'b0;
          r_state <= WM_IDLE;
        end
        default: r_state <= WM_IDLE;
      endcase
    end
  end

  assign HADDR      = w_addr;
  assign HTRANS     = w_htrans;
  assign HWRITE     = r_busy;
  assign HSIZE      = HSIZE_WORD;
  assign HBURST     = HBURST_INCR;
  assign HWDATA     = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_left = r_words_left;

endmodule
